// File: rtl/zynet_axil_cfg_slave.sv
// zynet_axil_cfg_slave: AXI4-Lite zyNet config register file (AW/W/B, AR/R, cfg strobes, result/neuron readback, interrupt)
module zynet_axil_cfg_slave #(
  parameter int C_ADDR_WIDTH = 5,
  parameter int C_DATA_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_OUT = 10
) (
  input  logic                           s_axi_aclk,
  input  logic                           rst,
  input  logic [C_ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]        layer_num,
  output logic [C_DATA_WIDTH-1:0]        neuron_num,
  output logic                           weight_valid,
  output logic                           bias_valid,
  output logic [DATA_WIDTH-1:0]          cfg_data,
  output logic                           soft_reset,
  input  logic [C_DATA_WIDTH-1:0]        result_in,
  input  logic                           result_valid,
  input  logic [NUM_OUT*DATA_WIDTH-1:0]  neuron_out_flat,
  output logic                           intr
);
  localparam int IW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  logic aw_en, result_seen, w_acc, ar_acc, unused;
  logic [2:0] w_sel, ar_sel;
  logic [C_DATA_WIDTH-1:0] result_q, rd;
  logic [DATA_WIDTH-1:0] nsel;
  logic [IW-1:0] idx;
  assign w_sel = s_axi_awaddr[4:2];
  assign w_acc = s_axi_awvalid && s_axi_wvalid && aw_en && !s_axi_awready;
  assign ar_acc = s_axi_arvalid && !s_axi_arready && !s_axi_rvalid;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign nsel = neuron_out_flat[idx*DATA_WIDTH +: DATA_WIDTH];
  assign unused = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  always_comb begin
    rd = ar_sel == 3'd2 ? result_q :
         ar_sel == 3'd3 ? layer_num :
         ar_sel == 3'd4 ? neuron_num :
         ar_sel == 3'd5 ? {{(C_DATA_WIDTH-DATA_WIDTH){nsel[DATA_WIDTH-1]}}, nsel} :
         ar_sel == 3'd6 ? {{(C_DATA_WIDTH-2){1'b0}}, intr, result_seen} :
         ar_sel == 3'd7 ? {{(C_DATA_WIDTH-1){1'b0}}, soft_reset} : '0;
  end
  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} <= '0;
      {weight_valid, bias_valid, intr, result_seen} <= '0;
      aw_en <= 1'b1;
      s_axi_rdata <= '0;
      layer_num <= '0;
      neuron_num <= '0;
      cfg_data <= '0;
      soft_reset <= 1'b1;
      result_q <= '0;
      idx <= '0;
      ar_sel <= '0;
    end else begin
      s_axi_awready <= w_acc;
      s_axi_wready <= w_acc;
      weight_valid <= w_acc && w_sel == 3'd0;
      bias_valid <= w_acc && w_sel == 3'd1;
      if (w_acc) aw_en <= 1'b0;
      else if (s_axi_bvalid && s_axi_bready) aw_en <= 1'b1;
      if (s_axi_awready) s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (w_acc && w_sel <= 3'd1) cfg_data <= s_axi_wdata[DATA_WIDTH-1:0];
      if (w_acc && w_sel == 3'd3) layer_num <= s_axi_wdata;
      if (w_acc && w_sel == 3'd4) neuron_num <= s_axi_wdata;
      if (w_acc && w_sel == 3'd7) soft_reset <= s_axi_wdata[0];
      s_axi_arready <= ar_acc;
      if (ar_acc) ar_sel <= s_axi_araddr[4:2];
      if (s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rd;
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
      if (soft_reset) begin
        intr <= 1'b0;
        result_q <= '0;
        result_seen <= 1'b0;
        idx <= '0;
      end else begin
        if (result_valid) begin
          result_q <= result_in;
          result_seen <= 1'b1;
          intr <= 1'b1;
        end else if (s_axi_arready && ar_sel == 3'd2) intr <= 1'b0;
        if (s_axi_arready && ar_sel == 3'd5) idx <= idx == IW'(NUM_OUT-1) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: doc/zynet_axil_cfg_slave.md
Name: zynet_axil_cfg_slave

Overview:
AXI4-Lite responder providing the zyNet control/configuration register file. Accepts host writes of layer/neuron selection, weights, biases and soft reset, and converts them into single-cycle configuration strobes toward the neuron array. Serves reads of the classification result, per-neuron outputs and status. Raises a level interrupt when a classification completes.

Parameters:
C_ADDR_WIDTH, 5, byte address width; only bits [4:2] decode a register
C_DATA_WIDTH, 32, AXI data width; only 32 is supported
DATA_WIDTH, 16, weight/bias/neuron-output width; sets `dataWidth
NUM_OUT, 10, number of final-layer neuron outputs readable at 0x14

Ports:
s_axi_aclk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_awaddr  in  C_ADDR_WIDTH  write address
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data (wstrb ignored, full-word writes only)
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  always 2'b00
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  C_ADDR_WIDTH  read address
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
layer_num  out  32  register 0x0C
neuron_num  out  32  register 0x10
weight_valid  out  1  one-cycle strobe on write to 0x00
bias_valid  out  1  one-cycle strobe on write to 0x04
cfg_data  out  DATA_WIDTH  wdata[DATA_WIDTH-1:0] of last 0x00/0x04 write
soft_reset  out  1  register 0x1C bit0, active-high
result_in  in  32  classification result
result_valid  in  1  one-cycle pulse, result_in valid
neuron_out_flat  in  NUM_OUT*DATA_WIDTH  final-layer outputs, neuron 0 in LSBs
intr  out  1  interrupt, level

Behaviour:
- Reset (rst=1 at posedge): all ready/valid outputs 0, rdata 0, layer_num 0, neuron_num 0, cfg_data 0, strobes 0, soft_reset 1, intr 0, result register 0, status 0, read index 0.
- Write: when awvalid&wvalid&aw_en&~awready, set awready=wready=1 for exactly one cycle and latch awaddr. Clear aw_en. Set bvalid next cycle. bvalid holds until bready. aw_en is re-set on the bvalid&bready cycle. A master that holds awvalid/wvalid one extra cycle after wready must not cause a second write.
- Register effect takes place in the cycle awready=1. Strobes are high in that same cycle.
- Write map:
  - 0x00: weight_valid=1, cfg_data=wdata.
  - 0x04: bias_valid=1, cfg_data=wdata.
  - 0x0C: layer_num=wdata.
  - 0x10: neuron_num=wdata.
  - 0x1C: soft_reset=wdata[0].
  - 0x08, 0x14, 0x18: accepted with OKAY, no effect.
- Read: when arvalid&~arready&~rvalid, set arready=1 for one cycle and latch the address. rvalid=1 next cycle with rdata. rvalid and rdata hold until rready. Read latency is arvalid-to-rvalid = 2 cycles.
- Read map:
  - 0x00, 0x04: 0.
  - 0x08: result register.
  - 0x0C, 0x10: current values.
  - 0x14: neuron_out_flat slice at read index, sign-extended to 32. Read index increments on each 0x14 read and wraps from NUM_OUT-1 to 0.
  - 0x18: status {30'b0, intr, result_seen}.
  - 0x1C: {31'b0, soft_reset}.
- result_valid captures result_in, sets intr=1 and sets status bit0.
- A read of 0x08 clears intr in the arready cycle. If result_valid occurs in that same cycle, set wins: intr stays 1 and the result register is updated. rdata returns the pre-update value, sampled at the arready cycle.
- soft_reset=1 clears intr, the result register, status and the read index, but does not affect the AXI handshake state.
- Simultaneous write and read channel activity is allowed and processed independently.
- rst asserted mid-transaction aborts the transaction immediately with no response issued.

Test Plan:
- rst for 3 cycles, then write 0x1C=0 -> awready one-cycle pulse, bvalid asserted next cycle, soft_reset=0, bresp=0.
- Write 0x0C=3, write 0x10=17, write 0x00=0x0000ABCD -> layer_num=3, neuron_num=17, weight_valid high exactly one cycle with cfg_data=0xABCD; master holding valid one extra cycle produces no second strobe.
- Write 0x04=0xFFF0 -> bias_valid one pulse, cfg_data=0xFFF0, weight_valid stays 0.
- Pulse result_valid with result_in=7 -> intr=1; read 0x18 returns 0x3; read 0x08 returns 7, rvalid 2 cycles after arvalid, intr=0 afterwards.
- neuron_out_flat with neuron k = k*0x100, k=0..9, neuron 9 = 0x8000 -> eleven reads of 0x14 return 0x0,0x100,...,0x800,0xFFFF8000, then 0x0 (wrap).
- result_valid in the same cycle as the 0x08 arready -> rdata holds the old result, intr remains 1.
